// File: rtl/cpu_reg_package.sv
// Shared CPU register-bus widths for the bridge and its peripherals.
package cpu_reg_package;
  parameter int unsigned address_width = 16;
  parameter int unsigned data_width    = 16;
endpackage

// File: rtl/bus_window_bridge_if.sv
// CPU-side and peripheral-side bus bundle of the window bridge.
interface bus_window_bridge_if #(
  parameter int unsigned NUM_WINDOWS = 4
) ();
  logic                                                cpuside_we_i;
  logic [cpu_reg_package::address_width-1:0]           cpuside_address_i;
  logic [cpu_reg_package::data_width-1:0]              cpuside_data_i;
  logic                                                cpuside_cpu_halt_o;
  logic [cpu_reg_package::data_width-1:0]              cpuside_module_data_o;
  logic [NUM_WINDOWS-1:0]                              moduleside_req_o;
  logic                                                moduleside_we_o;
  logic [cpu_reg_package::address_width-1:0]          moduleside_address_o;
  logic [cpu_reg_package::data_width-1:0]              moduleside_data_o;
  logic [NUM_WINDOWS-1:0]                              moduleside_rd_valid_i;
  logic [NUM_WINDOWS*cpu_reg_package::data_width-1:0]  moduleside_rd_data_i;

  // slave: the bridge itself; master: the CPU plus peripherals around it
  modport slave (
    input  cpuside_we_i, cpuside_address_i, cpuside_data_i,
           moduleside_rd_valid_i, moduleside_rd_data_i,
    output cpuside_cpu_halt_o, cpuside_module_data_o, moduleside_req_o,
           moduleside_we_o, moduleside_address_o, moduleside_data_o
  );

  modport master (
    output cpuside_we_i, cpuside_address_i, cpuside_data_i,
           moduleside_rd_valid_i, moduleside_rd_data_i,
    input  cpuside_cpu_halt_o, cpuside_module_data_o, moduleside_req_o,
           moduleside_we_o, moduleside_address_o, moduleside_data_o
  );
endinterface

// File: rtl/bus_window_bridge.sv
// Multi-window CPU bus bridge: decodes accesses, strobes the owning peripheral
// and halts the CPU on reads until data arrives or the access times out.
module bus_window_bridge #(
  parameter int unsigned NUM_WINDOWS = 4,
  parameter logic [NUM_WINDOWS*cpu_reg_package::address_width-1:0] WINDOW_START = '0,
  parameter logic [NUM_WINDOWS*cpu_reg_package::address_width-1:0] WINDOW_END   = '0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [cpu_reg_package::data_width-1:0] TIMEOUT_DATA = '1
) (
  input  logic clk_i,
  input  logic cpu_reset_i,
  bus_window_bridge_if.slave bus,
  input  logic timeout_clear_i,
  output logic timeout_flag_o,
  output logic [((NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1)-1:0] timeout_window_o
);
  localparam int unsigned AW = cpu_reg_package::address_width;
  localparam int unsigned DW = cpu_reg_package::data_width;
  localparam int unsigned IW = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 r_state, w_next;
  logic [AW-1:0]          r_addr;
  logic [NUM_WINDOWS-1:0] r_req;
  logic                   r_mwe;
  logic [AW-1:0]          r_maddr;
  logic [DW-1:0]          r_mdata;
  logic [IW-1:0]          r_sel;
  logic [CW-1:0]          r_cnt;
  logic [DW-1:0]          r_rdata;
  logic                   r_tflag;
  logic [IW-1:0]          r_twin;

  logic                   w_in_win, w_hit, w_halt, w_accept, w_capture, w_timeout;
  logic [IW-1:0]          w_win;
  logic [NUM_WINDOWS-1:0] w_onehot;
  logic                   w_valid, w_tmo;
  logic [DW-1:0]          w_slice;
  logic [CW-1:0]          w_cnt_inc;

  // First matching window wins, so overlaps resolve to the lowest index.
  always_comb begin
    w_in_win = 1'b0;
    w_win    = '0;
    w_onehot = '0;
    for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
      if (!w_in_win &&
          bus.cpuside_address_i >= WINDOW_START[i*AW +: AW] &&
          bus.cpuside_address_i <= WINDOW_END[i*AW +: AW]) begin
        w_in_win    = 1'b1;
        w_win       = IW'(i);
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Gating with reset keeps halt low while reset is held, whatever the CPU drives.
  assign w_hit     = w_in_win && (bus.cpuside_address_i != r_addr) && !cpu_reset_i;
  assign w_valid   = bus.moduleside_rd_valid_i[r_sel];
  assign w_slice   = bus.moduleside_rd_data_i[r_sel*DW +: DW];
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_tmo     = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_halt    = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        w_next = IDLE;
        if (w_hit) begin
          w_accept = 1'b1;
          if (!bus.cpuside_we_i) begin
            w_halt = 1'b1;
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        w_halt = 1'b1;
        if (w_valid) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end else if (w_tmo) begin
          w_timeout = 1'b1;
          w_next    = RESP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      r_addr  <= '0;
      r_req   <= '0;
      r_mwe   <= 1'b0;
      r_maddr <= '0;
      r_mdata <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_tflag <= 1'b0;
      r_twin  <= '0;
    end else begin
      r_addr  <= bus.cpuside_address_i;
      r_req   <= w_accept ? w_onehot : '0;
      r_mwe   <= w_accept & bus.cpuside_we_i;
      r_maddr <= w_accept ? bus.cpuside_address_i : '0;
      r_mdata <= w_accept ? bus.cpuside_data_i : '0;
      if (w_accept) r_sel <= w_win;
      r_cnt <= (r_state == WAIT) ? w_cnt_inc : '0;
      if (w_capture)      r_rdata <= w_slice;
      else if (w_timeout) r_rdata <= TIMEOUT_DATA;
      // A timeout in the same cycle as a clear takes precedence over the clear.
      if (w_timeout) begin
        r_tflag <= 1'b1;
        if (!r_tflag || timeout_clear_i) r_twin <= r_sel;
      end else if (timeout_clear_i) begin
        r_tflag <= 1'b0;
        r_twin  <= '0;
      end
    end
  end

  assign bus.cpuside_cpu_halt_o    = w_halt;
  assign bus.cpuside_module_data_o = (r_state == RESP) ? r_rdata : '0;
  assign bus.moduleside_req_o      = r_req;
  assign bus.moduleside_we_o       = r_mwe;
  assign bus.moduleside_address_o  = r_maddr;
  assign bus.moduleside_data_o     = r_mdata;
  assign timeout_flag_o            = r_tflag;
  assign timeout_window_o          = r_twin;
endmodule

// File: tb/tb_bus_window_bridge.sv
// Scoreboard bench for bus_window_bridge: stimulus queues expected requests and
// read responses, a negedge monitor pops and compares them.
module tb_bus_window_bridge;
  logic       clk;
  logic       rst;
  logic       tclr;
  logic       tflag;
  logic [1:0] twin;

  bus_window_bridge_if #(.NUM_WINDOWS(4)) bus ();

  bus_window_bridge #(
    .NUM_WINDOWS   (4),
    .WINDOW_START  ({16'h0400, 16'h0300, 16'h0200, 16'h0100}),
    .WINDOW_END    ({16'h04FF, 16'h03FF, 16'h02FF, 16'h01FF}),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA  (16'hFFFF)
  ) dut (
    .clk_i           (clk),
    .cpu_reset_i     (rst),
    .bus             (bus),
    .timeout_clear_i (tclr),
    .timeout_flag_o  (tflag),
    .timeout_window_o(twin)
  );

  typedef struct {
    logic [3:0]  req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  req_t        exp_req[$];
  logic [15:0] exp_rd[$];
  int          errors = 0;
  int          checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push_req(input logic [3:0] r, input logic w, input logic [15:0] a, input logic [15:0] d);
    req_t e;
    e.req = r; e.we = w; e.addr = a; e.data = d;
    exp_req.push_back(e);
  endtask

  // Monitor: request strobes and read responses (falling halt) against the queues.
  initial begin
    logic prev_halt;
    req_t e;
    prev_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_halt = 1'b0;
        continue;
      end
      if (bus.moduleside_req_o != 4'b0) begin
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got req 0x%0h addr 0x%0h, expected no request",
                   bus.moduleside_req_o, bus.moduleside_address_o);
        end else begin
          e = exp_req.pop_front();
          chk("req_onehot", {28'd0, bus.moduleside_req_o}, {28'd0, e.req});
          chk("req_we",     {31'd0, bus.moduleside_we_o},  {31'd0, e.we});
          chk("req_addr",   {16'd0, bus.moduleside_address_o}, {16'd0, e.addr});
          chk("req_data",   {16'd0, bus.moduleside_data_o},    {16'd0, e.data});
        end
      end else begin
        chk("req_idle_qual", {15'd0, bus.moduleside_we_o, bus.moduleside_address_o},
            {15'd0, 1'b0, 16'h0000});
        chk("req_idle_data", {16'd0, bus.moduleside_data_o}, 32'd0);
      end
      if (prev_halt && !bus.cpuside_cpu_halt_o) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got data 0x%0h, expected no response",
                   bus.cpuside_module_data_o);
        end else begin
          chk("rd_resp", {16'd0, bus.cpuside_module_data_o}, {16'd0, exp_rd.pop_front()});
        end
      end else begin
        chk("cpu_data_zero", {16'd0, bus.cpuside_module_data_o}, 32'd0);
      end
      prev_halt = bus.cpuside_cpu_halt_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tclr = 1'b0;
    bus.cpuside_we_i = 1'b0;
    bus.cpuside_address_i = 16'h0;
    bus.cpuside_data_i = 16'h0;
    bus.moduleside_rd_valid_i = 4'b0;
    bus.moduleside_rd_data_i = 64'h0;

    // Reset state
    nxt(); nxt(); neg();
    chk("rst_halt",  {31'd0, bus.cpuside_cpu_halt_o}, 32'd0);
    chk("rst_data",  {16'd0, bus.cpuside_module_data_o}, 32'd0);
    chk("rst_req",   {28'd0, bus.moduleside_req_o}, 32'd0);
    chk("rst_we",    {31'd0, bus.moduleside_we_o}, 32'd0);
    chk("rst_addr",  {16'd0, bus.moduleside_address_o}, 32'd0);
    chk("rst_wdata", {16'd0, bus.moduleside_data_o}, 32'd0);
    chk("rst_flag",  {31'd0, tflag}, 32'd0);
    chk("rst_win",   {30'd0, twin}, 32'd0);
    nxt();
    rst = 1'b0;
    nxt();

    // Write 0x210 <- 0xA5, then repeat the same address
    bus.cpuside_we_i = 1'b1;
    bus.cpuside_address_i = 16'h0210;
    bus.cpuside_data_i = 16'h00A5;
    push_req(4'b0010, 1'b1, 16'h0210, 16'h00A5);
    neg(); chk("wr_halt_n", {31'd0, bus.cpuside_cpu_halt_o}, 32'd0);
    nxt(); neg(); chk("wr_halt_n1", {31'd0, bus.cpuside_cpu_halt_o}, 32'd0);
    nxt(); neg(); chk("wr_same_addr_noreq", {28'd0, bus.moduleside_req_o}, 32'd0);
    nxt();
    bus.cpuside_we_i = 1'b0;
    bus.cpuside_address_i = 16'h0;
    bus.cpuside_data_i = 16'h0;
    nxt();

    // Read 0x305, window 2 answers 3 cycles after the request; window 3 noise in WAIT
    bus.cpuside_address_i = 16'h0305;
    push_req(4'b0100, 1'b0, 16'h0305, 16'h0000);
    exp_rd.push_back(16'h1234);
    neg(); chk("rd_hit_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    nxt(); neg(); chk("rd_req_cycle_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    nxt();
    bus.moduleside_rd_valid_i = 4'b1000;
    bus.moduleside_rd_data_i[63:48] = 16'h7777;
    neg(); chk("rd_spurious_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    nxt();
    bus.moduleside_rd_valid_i = 4'b0000;
    neg(); chk("rd_wait_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    nxt();
    bus.moduleside_rd_valid_i = 4'b0100;
    bus.moduleside_rd_data_i[47:32] = 16'h1234;
    neg(); chk("rd_valid_cycle_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    nxt();
    bus.moduleside_rd_valid_i = 4'b0000;
    neg();
    chk("rd_resp_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd0);
    chk("rd_resp_data", {16'd0, bus.cpuside_module_data_o}, 32'h1234);
    nxt();
    bus.cpuside_address_i = 16'h0;
    neg(); chk("rd_after_data", {16'd0, bus.cpuside_module_data_o}, 32'd0);
    nxt();

    // Read 0x100 with valid in the request cycle -> data in N+2
    bus.cpuside_address_i = 16'h0100;
    push_req(4'b0001, 1'b0, 16'h0100, 16'h0000);
    exp_rd.push_back(16'hBEEF);
    neg(); chk("fast_hit_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    nxt();
    bus.moduleside_rd_valid_i = 4'b1001;
    bus.moduleside_rd_data_i[15:0] = 16'hBEEF;
    bus.moduleside_rd_data_i[63:48] = 16'h7777;
    neg(); chk("fast_req_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    nxt();
    bus.moduleside_rd_valid_i = 4'b0000;
    neg();
    chk("fast_n2_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd0);
    chk("fast_n2_data", {16'd0, bus.cpuside_module_data_o}, 32'hBEEF);
    nxt();
    bus.cpuside_address_i = 16'h0;
    nxt();

    // Timeout on window 3 after 8 WAIT cycles
    bus.cpuside_address_i = 16'h0450;
    push_req(4'b1000, 1'b0, 16'h0450, 16'h0000);
    exp_rd.push_back(16'hFFFF);
    neg(); chk("tmo_hit_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      nxt(); neg();
      chk("tmo_wait_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    end
    nxt(); neg();
    chk("tmo_resp_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd0);
    chk("tmo_resp_data", {16'd0, bus.cpuside_module_data_o}, 32'hFFFF);
    chk("tmo_flag",      {31'd0, tflag}, 32'd1);
    chk("tmo_window",    {30'd0, twin}, 32'd3);
    nxt();
    bus.cpuside_address_i = 16'h0;
    nxt();

    // Second timeout on window 0 keeps the first index
    bus.cpuside_address_i = 16'h0150;
    push_req(4'b0001, 1'b0, 16'h0150, 16'h0000);
    exp_rd.push_back(16'hFFFF);
    repeat (9) nxt();
    neg();
    chk("tmo2_resp_data", {16'd0, bus.cpuside_module_data_o}, 32'hFFFF);
    chk("tmo2_flag",      {31'd0, tflag}, 32'd1);
    chk("tmo2_window",    {30'd0, twin}, 32'd3);
    nxt();
    bus.cpuside_address_i = 16'h0;
    tclr = 1'b1;
    nxt();
    tclr = 1'b0;
    neg();
    chk("clr_flag",   {31'd0, tflag}, 32'd0);
    chk("clr_window", {30'd0, twin}, 32'd0);
    nxt();

    // Reset during WAIT of a read of 0x200; late valid must not reach the CPU
    bus.cpuside_address_i = 16'h0200;
    push_req(4'b0010, 1'b0, 16'h0200, 16'h0000);
    nxt();
    nxt();
    neg(); chk("rstw_pre_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd1);
    #2;
    rst = 1'b1;
    bus.cpuside_address_i = 16'h0;
    #1;
    chk("rstw_async_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd0);
    chk("rstw_async_data", {16'd0, bus.cpuside_module_data_o}, 32'd0);
    nxt(); nxt();
    rst = 1'b0;
    bus.moduleside_rd_valid_i = 4'b0010;
    bus.moduleside_rd_data_i[31:16] = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("rstw_late_halt", {31'd0, bus.cpuside_cpu_halt_o}, 32'd0);
      chk("rstw_late_data", {16'd0, bus.cpuside_module_data_o}, 32'd0);
      nxt();
    end
    bus.moduleside_rd_valid_i = 4'b0000;
    nxt(); nxt();

    chk("req_queue_drained", exp_req.size(), 32'd0);
    chk("rd_queue_drained",  exp_rd.size(),  32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
